// File: rtl/regfile_read_arbiter.sv
// Round-robin read-port arbiter: grants one of four requesters per cycle, drives the register
// read mux select, then returns the resolved data (x0 reads zero, same-cycle write bypass).
module regfile_read_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0][AW-1:0]  raddr,
    input  logic                     stall,
    input  logic [DW-1:0]            mux_data,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
    output logic [AW-1:0]            sel,
    output logic [NREQ-1:0]          gnt,
    output logic [DW-1:0]            rdata,
    output logic [NREQ-1:0]          rvalid,
    output logic                     busy
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_pend;
    logic [NREQ-1:0] r_rvalid;
    logic [AW-1:0]   r_sel;
    logic [DW-1:0]   r_rdata;
    logic [PW-1:0]   r_ptr;

    logic            w_found;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_winIdx;
    logic [NREQ-1:0] w_oneHot;
    logic [DW-1:0]   w_resolved;

    // The requester holding gnt this cycle is masked so a held req counts as a new request later.
    always_comb begin
        w_found  = 1'b0;
        w_idx    = '0;
        w_winIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = r_ptr + PW'(k);
            if (!w_found && req[w_idx] && !r_gnt[w_idx]) begin
                w_found  = 1'b1;
                w_winIdx = w_idx;
            end
        end
        w_oneHot = {{(NREQ-1){1'b0}}, 1'b1} << w_winIdx;
    end

    always_comb begin
        if (r_sel == '0) begin
            w_resolved = '0;
        end else if (wr_en && (wr_addr == r_sel)) begin
            w_resolved = wr_data;
        end else begin
            w_resolved = mux_data;
        end
    end

    // r_pend tracks the owner awaiting stage 2; unlike gnt it survives a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt    <= '0;
            r_pend   <= '0;
            r_rvalid <= '0;
            r_sel    <= '0;
            r_rdata  <= '0;
            r_ptr    <= '0;
        end else if (stall) begin
            r_gnt    <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= r_pend;
            if (|r_pend) begin
                r_rdata <= w_resolved;
            end
            if (w_found) begin
                r_gnt  <= w_oneHot;
                r_pend <= w_oneHot;
                r_sel  <= raddr[w_winIdx];
                r_ptr  <= w_winIdx + PW'(1);
            end else begin
                r_gnt  <= '0;
                r_pend <= '0;
            end
        end
    end

    assign sel    = r_sel;
    assign gnt    = r_gnt;
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign busy   = (|r_gnt) | (|r_pend);

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench: stimulus process runs a behavioural model and queues expectations,
// a monitor process samples the DUT after each rising edge and compares.
module tb_regfile_read_arbiter;

    typedef struct {
        logic [3:0]  gnt;
        logic [4:0]  sel;
        logic        busy;
        logic [3:0]  rvalid;
        logic [31:0] rdata;
    } status_t;

    typedef struct {
        int          owner;
        logic [31:0] data;
    } read_t;

    logic            clk;
    logic            reset;
    logic [3:0]      req;
    logic [3:0][4:0] raddr;
    logic            stall;
    logic [31:0]     mux_data;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [31:0]     wr_data;
    logic [4:0]      sel;
    logic [3:0]      gnt;
    logic [31:0]     rdata;
    logic [3:0]      rvalid;
    logic            busy;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    status_t statusQ[$];
    read_t   readQ[$];

    // Model state: whole-number view of the arbiter (-1 means nobody).
    int          mPtr   = 0;
    int          mGnt   = -1;
    int          mPend  = -1;
    int          mSel   = 0;
    logic [31:0] mRdata = '0;

    logic [3:0]      curReq;
    logic [3:0][4:0] curAddr;

    regfile_read_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset), .req(req), .raddr(raddr), .stall(stall),
        .mux_data(mux_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sel(sel), .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, then predicts what the next rising edge produces.
    task automatic applyStimulus(input logic rst, input logic st, input logic [3:0] rq,
                                 input logic [3:0][4:0] ra, input logic [31:0] md,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
        status_t s;
        int w;
        @(negedge clk);
        reset = rst; stall = st; req = rq; raddr = ra;
        mux_data = md; wr_en = we; wr_addr = wa; wr_data = wd;
        started = 1;
        s.rvalid = 4'b0000;
        if (rst) begin
            mPtr = 0; mGnt = -1; mPend = -1; mSel = 0; mRdata = '0;
        end else if (st) begin
            mGnt = -1;
        end else begin
            if (mPend >= 0) begin
                read_t r;
                if (mSel == 0)                       mRdata = 32'h0;
                else if (we && int'(wa) == mSel)     mRdata = wd;
                else                                 mRdata = md;
                r.owner = mPend;
                r.data  = mRdata;
                readQ.push_back(r);
                s.rvalid = 4'b0001 << mPend;
            end
            w = -1;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (mPtr + k) % 4;
                if (w < 0 && rq[i] && i != mGnt) w = i;
            end
            mGnt  = w;
            mPend = w;
            if (w >= 0) begin
                mSel = int'(ra[w]);
                mPtr = (w + 1) % 4;
            end
        end
        s.gnt   = (mGnt >= 0) ? (4'b0001 << mGnt) : 4'b0000;
        s.sel   = 5'(mSel);
        s.busy  = (mGnt >= 0) || (mPend >= 0);
        s.rdata = mRdata;
        statusQ.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) applyStimulus(0, 0, 4'b0000, '0, 32'h1234_5678, 0, 5'd0, 32'h0);
    endtask

    // Monitor: per-cycle status compare plus read scoreboard popped on rvalid.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (statusQ.size() == 0) begin
                    checkOutput("status_queue_empty", 32'(statusQ.size()), 32'd1);
                end else begin
                    status_t s;
                    s = statusQ.pop_front();
                    checkOutput("gnt", 32'(gnt), 32'(s.gnt));
                    checkOutput("sel", 32'(sel), 32'(s.sel));
                    checkOutput("busy", 32'(busy), 32'(s.busy));
                    checkOutput("rvalid", 32'(rvalid), 32'(s.rvalid));
                    checkOutput("rdata", rdata, s.rdata);
                end
                checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
                checkOutput("rvalid_onehot0", 32'($onehot0(rvalid)), 32'd1);
                if (rvalid != 4'b0000) begin
                    if (readQ.size() == 0) begin
                        checkOutput("rd_unexpected", 32'(rvalid), 32'd0);
                    end else begin
                        read_t r;
                        r = readQ.pop_front();
                        checkOutput("rd_owner", 32'(rvalid), 32'(4'b0001 << r.owner));
                        checkOutput("rd_data", rdata, r.data);
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0][4:0] ra;
        reset = 1; stall = 0; req = '0; raddr = '0;
        mux_data = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        curReq = '0; curAddr = '0;

        applyStimulus(1, 0, 4'b0000, '0, 32'h0, 0, 5'd0, 32'h0);
        applyStimulus(1, 1, 4'b1111, '0, 32'h0, 0, 5'd0, 32'h0);

        // Single read by requester 1 from register 7.
        ra = '0; ra[1] = 5'd7;
        applyStimulus(0, 0, 4'b0010, ra, 32'hA5A5_0007, 0, 5'd0, 32'h0);
        applyStimulus(0, 0, 4'b0000, ra, 32'hA5A5_0007, 0, 5'd0, 32'h0);
        idle(1);

        // Full contention from ptr=0.
        applyStimulus(1, 0, 4'b0000, '0, 32'h0, 0, 5'd0, 32'h0);
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3; ra[3] = 5'd4;
        for (int j = 0; j < 6; j++) applyStimulus(0, 0, 4'b1111, ra, 32'hC0DE_0000 + j, 0, 5'd0, 32'h0);
        idle(2);

        // Register zero, then write bypass on register 9.
        ra = '0;
        applyStimulus(0, 0, 4'b0001, ra, 32'hFFFF_FFFF, 0, 5'd0, 32'h0);
        applyStimulus(0, 0, 4'b0000, ra, 32'hFFFF_FFFF, 1, 5'd0, 32'h1111_1111);
        ra[0] = 5'd9;
        applyStimulus(0, 0, 4'b0001, ra, 32'h5555_5555, 0, 5'd0, 32'h0);
        applyStimulus(0, 0, 4'b0000, ra, 32'h5555_5555, 1, 5'd9, 32'hDEAD_BEEF);
        idle(1);

        // Grant to requester 2, then three stalled cycles.
        ra = '0; ra[2] = 5'd12;
        applyStimulus(0, 0, 4'b0100, ra, 32'h0, 0, 5'd0, 32'h0);
        for (int j = 0; j < 3; j++) applyStimulus(0, 1, 4'b1011, ra, 32'hBAD0_0000 + j, 0, 5'd0, 32'h0);
        applyStimulus(0, 0, 4'b0000, ra, 32'h0C0C_000C, 0, 5'd0, 32'h0);
        idle(1);

        // Reset the cycle after a grant to requester 0.
        ra = '0; ra[0] = 5'd3; ra[1] = 5'd5; ra[2] = 5'd6; ra[3] = 5'd8;
        applyStimulus(0, 0, 4'b0001, ra, 32'h0, 0, 5'd0, 32'h0);
        applyStimulus(1, 0, 4'b0000, ra, 32'h7777_7777, 0, 5'd0, 32'h0);
        applyStimulus(0, 0, 4'b1111, ra, 32'h0, 0, 5'd0, 32'h0);
        applyStimulus(0, 0, 4'b0000, ra, 32'h2222_2222, 0, 5'd0, 32'h0);
        idle(2);

        // Randomized traffic: requesters hold until granted, then drop or re-request.
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        st;
            logic        rst;
            logic        we;
            logic [4:0]  wa;
            for (int i = 0; i < 4; i++) begin
                if (curReq[i]) begin
                    if (mGnt == i) begin
                        if ($urandom_range(0, 1) == 0) curReq[i] = 1'b0;
                        else curAddr[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    curReq[i]  = 1'b1;
                    curAddr[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                end
            end
            st  = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 99) == 0);
            we  = ($urandom_range(0, 1) == 1);
            wa  = ($urandom_range(0, 1) == 1) ? 5'(mSel) : 5'($urandom_range(0, 31));
            applyStimulus(rst, st, curReq, curAddr, $urandom, we, wa, $urandom);
        end

        idle(4);
        @(posedge clk);
        #2;
        checkOutput("status_leftover", 32'(statusQ.size()), 32'd0);
        checkOutput("read_leftover", 32'(readQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_read_arbiter.md
REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of read requesters (fixed 4 in this revision).
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  [3:0]  per-requester read request.
REQ-007 SHALL have port raddr  input  [3:0][4:0]  per-requester register address, stable while req high.
REQ-008 SHALL have port stall  input  1  freeze; no new grant, pipeline holds.
REQ-009 SHALL have port mux_data  input  [31:0]  output of the external 32x32 register read mux.
REQ-010 SHALL have port wr_en  input  1  register file write this cycle.
REQ-011 SHALL have port wr_addr  input  [4:0]  write address.
REQ-012 SHALL have port wr_data  input  [31:0]  write data.
REQ-013 SHALL have port sel  output  [4:0]  registered select driven to the read mux.
REQ-014 SHALL have port gnt  output  [3:0]  registered one-hot grant, one-cycle pulse.
REQ-015 SHALL have port rdata  output  [31:0]  registered read data.
REQ-016 SHALL have port rvalid  output  [3:0]  registered one-hot, marks owner of rdata, one-cycle pulse.
REQ-017 SHALL have port busy  output  1  high when gnt or a read in stage 2 is outstanding.

Function
REQ-018 SHALL arbitrate at every rising edge with stall low among eligible requesters: req[i]=1 and gnt[i]=0 (requester being granted this cycle is masked).
REQ-019 SHALL use round-robin: search starts at pointer ptr (2 bits), first eligible index in order ptr, ptr+1, ..., wrapping mod 4.
REQ-020 SHALL, on a win by index w, set gnt=one-hot(w), sel=raddr[w], ptr=(w+1) mod 4 at that edge.
REQ-021 SHALL, with no eligible requester, set gnt=0, hold sel and ptr.
REQ-022 SHALL form stage 2 at the edge after a grant: rvalid=gnt of previous cycle, rdata=resolved value for sel.
REQ-023 SHALL resolve rdata priority: sel==0 -> 32'h0; else wr_en && wr_addr==sel -> wr_data (bypass); else mux_data.
REQ-024 SHALL deliver latency: request seen at edge E -> gnt high during E..E+1 -> rvalid with data during E+1..E+2.
REQ-025 SHALL sustain one grant per cycle (pipelined), alternating requesters when multiple are pending.
REQ-026 SHALL, when a granted requester keeps req high with a new raddr after its gnt cycle, treat it as a new request.
REQ-027 SHALL, with stall high at an edge, force gnt=0 and rvalid=0, hold sel, ptr, rdata; an in-flight grant completes its stage 2 at the first non-stall edge.
REQ-028 SHALL drive busy = |gnt | pending stage-2 flag.
REQ-029 SHALL never assert more than one gnt bit or more than one rvalid bit.

Reset
REQ-030 SHALL, with reset high at an edge, set gnt=0, rvalid=0, rdata=0, sel=0, ptr=0, pending flag=0, busy=0; reset overrides stall and any request.
REQ-031 SHALL discard an in-flight read on reset mid-operation (no rvalid after reset deasserts).

Verification
REQ-032 Single read: req=4'b0010, raddr[1]=7, mux_data=32'hA5A5_0007 -> gnt=4'b0010 next cycle, sel=7, then rvalid=4'b0010, rdata=32'hA5A5_0007.
REQ-033 Contention: req=4'b1111 held continuously, ptr=0 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, rvalid trails by one cycle.
REQ-034 Zero and bypass: raddr=0 -> rdata=0 regardless of mux_data; raddr=9 with wr_en=1, wr_addr=9, wr_data=32'hDEAD_BEEF in stage-2 cycle -> rdata=32'hDEAD_BEEF.
REQ-035 Stall: grant to requester 2 issued, stall=1 for 3 cycles -> gnt=0, rvalid=0, sel held; after stall drops rvalid=4'b0100 with correct data.
REQ-036 Reset mid-operation: reset asserted the cycle after gnt=4'b0001 -> all outputs 0 next edge, no rvalid afterward, next grant with req=4'b1111 goes to requester 0.
